// File: rtl/queue33_reader_pkg.sv
// Shared definitions for the 33-bit message queue reader: word layout, state encodings, defaults.
package queue33_reader_pkg;

  localparam int LAST_BIT  = 32;
  localparam int LEN_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BODY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/queue33_reader.sv
// Consumer-side controller for the 33-bit message queue: pops words into a one-deep output
// register and reports message length at message end. Optional feature macro: QREADER_LENCHK_EN.
module queue33_reader
  import queue33_reader_pkg::*;
#(
  parameter int DW      = LAST_BIT,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MAX_LEN = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW:0]      q_dout,
  input  logic             q_empty,
  output logic             q_rd_en,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             msg_done,
  output logic [LEN_W-1:0] msg_len,
  output logic             msg_err
);

  if (MAX_LEN >= 2**LEN_W) begin : g_bad_max_len
    $error("queue33_reader: MAX_LEN must be below 2**LEN_W");
  end

  state_t           state;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_inc;
  logic             err_q;
  logic             pop;
  logic             in_last;
  logic             trunc;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // The queue has no underflow guard, so the pop must be gated by q_empty here.
  assign pop       = !q_empty && (state == ST_FLUSH || !out_valid || out_ready);
  assign q_rd_en   = pop;
  assign in_last   = q_dout[DW];
  assign count_inc = sat_inc(count);

`ifdef QREADER_LENCHK_EN
  assign trunc = pop && (state != ST_FLUSH) && !in_last && (count == LEN_W'(MAX_LEN - 1));
`else
  assign trunc = 1'b0;
`endif

  // msg_len/err_q are captured with the last word, so they stay aligned to its handshake.
  assign msg_done = out_valid && out_ready && out_last;
  assign msg_err  = msg_done && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      msg_len   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (pop && state != ST_FLUSH) begin
        out_valid <= 1'b1;
        out_data  <= q_dout[DW-1:0];
        out_last  <= in_last || trunc;
      end

      if (pop) begin
        case (state)
          ST_IDLE, ST_BODY: begin
            if (in_last || trunc) begin
              msg_len <= count_inc;
              err_q   <= trunc;
              count   <= '0;
              state   <= trunc ? ST_FLUSH : ST_IDLE;
            end else begin
              count <= count_inc;
              state <= ST_BODY;
            end
          end
          ST_FLUSH: begin
            if (in_last)
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
